// File: rtl/gpio_pkg.sv
// Shared widths and the arm-state encoding for the GPIO event path.
package gpio_pkg;

  localparam int unsigned GPIO_DW          = 8;
  localparam int unsigned GPIO_DB_CW       = 8;
  localparam int unsigned GPIO_SYNC_STAGES = 2;

  typedef enum logic {
    PRIME = 1'b0,
    ARMED = 1'b1
  } arm_state_t;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One GPIO bit: pad synchronizer, debounce counter, filtered level flop and
// registered edge-event pulse.
module gpio_debounce_bit
  import gpio_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int unsigned DB_CW       = GPIO_DB_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             gpio,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             db_en,
  input  logic [DB_CW-1:0] db_limit,
  input  logic             armed,
  output logic             status,
  output logic             level
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [DB_CW-1:0]       limit_eff;
  logic [DB_CW-1:0]       cnt_q;
  logic [DB_CW-1:0]       cnt_nxt;
  logic                   filt_q;
  logic                   filt_nxt;
  logic                   status_q;
  logic                   status_nxt;

  // Pad synchronizer chain; the raw pad feeds the first flop directly.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Debounce disabled is simply a zero stability limit.
  assign limit_eff = db_en ? db_limit : '0;

  // Next filtered level, counter and event pulse.
  always_comb begin
    cnt_nxt    = '0;
    filt_nxt   = filt_q;
    status_nxt = 1'b0;
    if (!armed) begin
      filt_nxt = synced;
    end else if (synced == filt_q) begin
      cnt_nxt = '0;
    end else if (cnt_q >= limit_eff) begin
      filt_nxt = synced;
      cnt_nxt  = '0;
    end else if (cnt_q != '1) begin
      cnt_nxt = cnt_q + DB_CW'(1);
    end else begin
      cnt_nxt = cnt_q;
    end
    status_nxt = armed & ((rise_en & filt_nxt & ~filt_q) |
                          (fall_en & ~filt_nxt & filt_q));
  end

  // Filter state and event register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      filt_q   <= 1'b0;
      status_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_nxt;
      filt_q   <= filt_nxt;
      status_q <= status_nxt;
    end
  end

  assign status = status_q;
  assign level  = filt_q;

endmodule

// File: rtl/gpio_event_gen.sv
// GPIO event generator: per-bit synchronize/debounce/edge-detect with a
// post-reset priming phase that suppresses spurious events.
module gpio_event_gen
  import gpio_pkg::*;
#(
  parameter int unsigned DW          = GPIO_DW,
  parameter int unsigned SYNC_STAGES = GPIO_SYNC_STAGES,
  parameter int unsigned DB_CW       = GPIO_DB_CW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DW-1:0]    gpio_i,
  input  logic [DW-1:0]    rise_en_i,
  input  logic [DW-1:0]    fall_en_i,
  input  logic [DW-1:0]    db_en_i,
  input  logic [DB_CW-1:0] db_limit_i,
  output logic [DW-1:0]    status_o,
  output logic [DW-1:0]    level_o,
  output logic             armed_o
);

  localparam int unsigned       CNT_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]  ARM_LAST = CNT_W'(SYNC_STAGES);

  arm_state_t       state_q;
  arm_state_t       state_nxt;
  logic [CNT_W-1:0] arm_cnt_q;
  logic [CNT_W-1:0] arm_cnt_nxt;
  logic             armed;

  // Arm FSM state and priming counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PRIME;
      arm_cnt_q <= '0;
    end else begin
      state_q   <= state_nxt;
      arm_cnt_q <= arm_cnt_nxt;
    end
  end

  // Stay in PRIME for SYNC_STAGES+1 cycles so the filter flops pick up the
  // settled pad level before any edge can be reported.
  always_comb begin
    state_nxt   = state_q;
    arm_cnt_nxt = arm_cnt_q;
    unique case (state_q)
      PRIME: begin
        if (arm_cnt_q == ARM_LAST) begin
          state_nxt = ARMED;
        end else begin
          arm_cnt_nxt = arm_cnt_q + CNT_W'(1);
        end
      end
      ARMED: begin
        state_nxt = ARMED;
      end
      default: begin
        state_nxt   = PRIME;
        arm_cnt_nxt = '0;
      end
    endcase
  end

  assign armed   = (state_q == ARMED);
  assign armed_o = armed;

  for (genvar i = 0; i < DW; i++) begin : g_bit
    gpio_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CW       (DB_CW)
    ) u_bit (
      .clk      (clk),
      .rst      (rst),
      .gpio     (gpio_i[i]),
      .rise_en  (rise_en_i[i]),
      .fall_en  (fall_en_i[i]),
      .db_en    (db_en_i[i]),
      .db_limit (db_limit_i),
      .armed    (armed),
      .status   (status_o[i]),
      .level    (level_o[i])
    );
  end

endmodule

// File: tb/tb_gpio_event_gen.sv
// Directed bench for gpio_event_gen (DW=8, SYNC_STAGES=2, DB_CW=8).
module tb_gpio_event_gen;

  logic       clk;
  logic       rst;
  logic [7:0] gpio_i;
  logic [7:0] rise_en_i;
  logic [7:0] fall_en_i;
  logic [7:0] db_en_i;
  logic [7:0] db_limit_i;
  logic [7:0] status_o;
  logic [7:0] level_o;
  logic       armed_o;

  int unsigned tests;
  int unsigned fails;

  gpio_event_gen #(
    .DW          (8),
    .SYNC_STAGES (2),
    .DB_CW       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .gpio_i     (gpio_i),
    .rise_en_i  (rise_en_i),
    .fall_en_i  (fall_en_i),
    .db_en_i    (db_en_i),
    .db_limit_i (db_limit_i),
    .status_o   (status_o),
    .level_o    (level_o),
    .armed_o    (armed_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; gpio_i = 8'hFF; rise_en_i = 8'hFF; fall_en_i = 8'hFF;
    db_en_i = 8'h00; db_limit_i = 8'd0;
    tick(); tick(); tick();
    tests++;
    if (status_o !== 8'h00 || level_o !== 8'h00 || armed_o !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: status=%h level=%h armed=%b need 00/00/0",
               status_o, level_o, armed_o);
    end
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      tests++;
      if (status_o !== 8'h00) begin
        fails++;
        $display("FAIL prime_status k=%0d: got %h need 00", k, status_o);
      end
      tests++;
      if (armed_o !== (k >= 3)) begin
        fails++;
        $display("FAIL prime_armed k=%0d: got %b need %b", k, armed_o, k >= 3);
      end
      if (k == 2 || k == 3) begin
        tests++;
        if (level_o !== ((k == 3) ? 8'hFF : 8'h00)) begin
          fails++;
          $display("FAIL prime_level k=%0d: got %h need %h", k, level_o,
                   (k == 3) ? 8'hFF : 8'h00);
        end
      end
    end
  endtask

  task automatic test_no_debounce();
    rise_en_i = 8'h00; fall_en_i = 8'h00; gpio_i = 8'h00;
    repeat (6) tick();
    rise_en_i = 8'h01;
    gpio_i[0] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests++;
      if (level_o[0] !== (k >= 3)) begin
        fails++;
        $display("FAIL nodb_level k=%0d: got %b need %b", k, level_o[0], k >= 3);
      end
      tests++;
      if (status_o !== ((k == 3) ? 8'h01 : 8'h00)) begin
        fails++;
        $display("FAIL nodb_status k=%0d: got %h need %h", k, status_o,
                 (k == 3) ? 8'h01 : 8'h00);
      end
    end
  endtask

  task automatic test_debounce();
    logic bad;
    db_limit_i = 8'd4; db_en_i = 8'h02; rise_en_i = 8'h02; fall_en_i = 8'h00;
    // 4-cycle glitch: must be filtered out.
    bad = 1'b0;
    gpio_i[1] = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 4) gpio_i[1] = 1'b0;
      if (level_o[1] !== 1'b0 || status_o !== 8'h00) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL db_glitch: level/event seen, got %b need 0", bad);
    end
    // 5-cycle pulse: accepted, filtered level rises at edge 2+4+1 = 7.
    gpio_i[1] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      tick();
      if (k == 5) gpio_i[1] = 1'b0;
      tests++;
      if (level_o[1] !== (k >= 7 && k < 12)) begin
        fails++;
        $display("FAIL db_level k=%0d: got %b need %b", k, level_o[1],
                 k >= 7 && k < 12);
      end
      tests++;
      if (status_o !== ((k == 7) ? 8'h02 : 8'h00)) begin
        fails++;
        $display("FAIL db_status k=%0d: got %h need %h", k, status_o,
                 (k == 7) ? 8'h02 : 8'h00);
      end
    end
  endtask

  task automatic test_edge_select();
    logic [7:0] exp;
    db_en_i = 8'h00; rise_en_i = 8'h00; fall_en_i = 8'h00; gpio_i = 8'h00;
    repeat (6) tick();
    rise_en_i = 8'h0F; fall_en_i = 8'hF0;
    gpio_i = 8'hFF;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 10) gpio_i = 8'h00;
      exp = (k == 3) ? 8'h0F : ((k == 13) ? 8'hF0 : 8'h00);
      tests++;
      if (status_o !== exp) begin
        fails++;
        $display("FAIL edge_sel k=%0d: got %h need %h", k, status_o, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    db_en_i = 8'h00; rise_en_i = 8'h10; fall_en_i = 8'h10;
    gpio_i[4] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) gpio_i[4] = 1'b0;
      tests++;
      if (status_o !== ((k == 3 || k == 4) ? 8'h10 : 8'h00)) begin
        fails++;
        $display("FAIL b2b k=%0d: got %h need %h", k, status_o,
                 (k == 3 || k == 4) ? 8'h10 : 8'h00);
      end
    end
  endtask

  task automatic test_midcount_limit();
    logic bad;
    db_en_i = 8'h04; db_limit_i = 8'd200; rise_en_i = 8'h04; fall_en_i = 8'h00;
    bad = 1'b0;
    gpio_i[2] = 1'b1;
    // Counter reaches 50 after edge 52.
    for (int k = 1; k <= 52; k++) begin
      tick();
      if (level_o[2] !== 1'b0 || status_o !== 8'h00) bad = 1'b1;
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL mid_hold: early change, got %b need 0", bad);
    end
    db_limit_i = 8'd10;
    tick();
    tests++;
    if (level_o[2] !== 1'b1 || status_o !== 8'h04) begin
      fails++;
      $display("FAIL mid_update: level2=%b status=%h need 1/04", level_o[2], status_o);
    end
    tick();
    tests++;
    if (status_o !== 8'h00) begin
      fails++;
      $display("FAIL mid_single: got %h need 00", status_o);
    end
  endtask

  task automatic test_reset_midcount();
    logic bad;
    db_en_i = 8'h08; db_limit_i = 8'd8; rise_en_i = 8'h08; fall_en_i = 8'h00;
    gpio_i = 8'h0D;
    for (int k = 1; k <= 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (status_o !== 8'h00 || level_o !== 8'h00 || armed_o !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: status=%h level=%h armed=%b need 00/00/0",
               status_o, level_o, armed_o);
    end
    bad = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (status_o !== 8'h00) bad = 1'b1;
      if (k <= 3) begin
        tests++;
        if (armed_o !== (k == 3)) begin
          fails++;
          $display("FAIL rst_prime k=%0d: got %b need %b", k, armed_o, k == 3);
        end
      end
    end
    tests++;
    if (bad !== 1'b0) begin
      fails++;
      $display("FAIL rst_noevent: event seen, got %b need 0", bad);
    end
    tests++;
    if (level_o !== 8'h0D) begin
      fails++;
      $display("FAIL rst_level: got %h need 0d", level_o);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_no_debounce();
    test_debounce();
    test_edge_select();
    test_back_to_back();
    test_midcount_limit();
    test_reset_midcount();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_event_gen.md
Name: gpio_event_gen

Overview:
- Producer end of the GPIO status path: turns raw pad inputs into one-cycle event pulses that feed the latching status register's status input.
- Per bit, it synchronizes the pad, applies an optional debounce filter, detects edges and gates them with per-bit rising/falling enables.
- Sits between the GPIO pads and the interrupt status register inside gpio_core.

Parameters:
- DW, 8, number of GPIO bits.
- SYNC_STAGES, 2, synchronizer depth (minimum 2).
- DB_CW, 8, debounce counter and limit width.

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- gpio_i  input  DW  raw asynchronous pad levels
- rise_en_i  input  DW  per-bit rising-edge event enable
- fall_en_i  input  DW  per-bit falling-edge event enable
- db_en_i  input  DW  per-bit debounce enable
- db_limit_i  input  DB_CW  shared debounce stability count L
- status_o  output  DW  one-cycle event pulses (to status register status_i)
- level_o  output  DW  filtered level per bit
- armed_o  output  1  high once post-reset priming is complete

Behaviour:
- Reset values: sync chain 0, filtered level 0, debounce counters 0, status_o 0, level_o 0, armed_o 0, arm counter 0.
- Synchronizer: gpio_i passes through SYNC_STAGES flops. synced = last stage. No logic on gpio_i before the first flop.
- Arm sequence, with states PRIME and ARMED:
  - PRIME after reset. An arm counter counts SYNC_STAGES+1 cycles.
  - While in PRIME, filtered level loads synced directly every cycle, debounce counters are held at 0, and status_o is forced to 0.
  - After SYNC_STAGES+1 cycles the state moves to ARMED and armed_o = 1. ARMED is left only by rst.
  - A pad held high through reset therefore produces no event.
- Debounce, per bit, in ARMED:
  - If synced == filt: counter is cleared.
  - If synced != filt and counter >= L: filt <= synced and counter is cleared.
  - Otherwise the counter increments, saturating at all-ones.
  - Result: filt changes L+1 cycles after synced changes, if synced stays stable.
  - A glitch shorter than L+1 cycles is rejected and restarts the count on its next occurrence.
  - The >= compare means lowering db_limit_i mid-count takes effect on the next cycle.
- db_en_i[i] = 0: the bit behaves as L = 0, so filt follows synced with 1 cycle of latency. Deasserting db_en mid-count updates filt on the next cycle.
- Edge detection: status_o[i] is registered.
  - status_o[i] <= armed & ((rise_en_i[i] & filt_nxt[i] & ~filt[i]) | (fall_en_i[i] & ~filt_nxt[i] & filt[i])).
  - Each pulse is exactly one cycle per filtered transition. Back-to-back opposite transitions give separate pulses.
- level_o = filt, registered.
- Latency from a gpio_i change sampled at clock edge 0:
  - synced changes at edge SYNC_STAGES.
  - filt changes at edge SYNC_STAGES+L+1.
  - status_o is high for the cycle after edge SYNC_STAGES+L+1, i.e. it is captured by downstream logic at edge SYNC_STAGES+L+2.
- Enable changes: rise_en_i and fall_en_i take effect combinationally on the next registered pulse. Changing an enable never generates an event by itself, and transitions occurring while disabled are lost (not queued).
- Bits are fully independent. Simultaneous events on several bits pulse together.
- rst mid-operation: returns to PRIME and discards in-flight counts and pending pulses. status_o is 0 in the cycle after rst.

Decomposition:
- gpio_pkg:
  - default widths GPIO_DW and GPIO_DB_CW
  - GPIO_SYNC_STAGES
  - arm state enum typedef (PRIME, ARMED)
- Sub-module gpio_debounce_bit: one bit's synchronizer, counter, filt flop and edge pulse. Instantiated DW times via generate.
- Top level holds the arm FSM and shared db_limit_i fan-out.

Test Plan:
1. Reset priming: gpio_i = 8'hFF through reset, rise_en = fall_en = 8'hFF. Release rst. Required: status_o stays 0, level_o = 8'hFF after 3 cycles, armed_o = 1 after 3 cycles.
2. No-debounce latency: SYNC_STAGES = 2, db_en = 0, rise_en[0] = 1. Raise gpio_i[0] at edge 0. Required: level_o[0] high after edge 3, status_o[0] high for exactly one cycle after edge 3.
3. Debounce filter: L = 4, db_en[1] = 1. First, a 4-cycle high glitch on gpio_i[1]. Required: no level change and no event. Then a 5-cycle high pulse. Required: level_o[1] rises 5 cycles after synced, with one rise event.
4. Edge selection: rise_en = 8'h0F, fall_en = 8'hF0. Toggle all bits 0→1→0 with gaps of 10 cycles. Required: pulses 8'h0F on the rise, then 8'hF0 on the fall.
5. Mid-count config change: L = 200. At counter ≈ 50, write L = 10. Required: filt updates the next cycle, with a single event.
6. Reset mid-count: assert rst while the bit-3 counter is at 3 of L = 8. Required: no event after release, and PRIME repeats for 3 cycles.
